// File: rtl/serial_word_cmp.sv
// serial_word_cmp: serial N-bit magnitude/equality comparator.
// Consumes one {a, b} bit pair per accepted handshake, accumulates an
// equal / greater / less verdict plus a mismatch count, and emits a
// one-cycle res_valid strobe when the WIDTH-th bit has been accepted.
// Optional build macro: SERIAL_CMP_MSB_FIRST_EN (bits arrive MSB first,
// first difference decides). Default build: LSB first, last difference wins.
module serial_word_cmp #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  output logic             res_valid,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] mism_cnt_q, mism_cnt_d;
  logic             dec_gt_q, dec_gt_d;   // pending decision while shifting
  logic             dec_lt_q, dec_lt_d;
  logic             eq_q, eq_d;           // final verdict, held until next start
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             bit_e;

  // Per-bit equality term of the presented pair.
  assign bit_e = ~(a ^ b);

  // Next-state and accumulator update for the word-level comparison.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    mism_cnt_d = mism_cnt_q;
    dec_gt_d   = dec_gt_q;
    dec_lt_d   = dec_lt_q;
    eq_d       = eq_q;
    gt_d       = gt_q;
    lt_d       = lt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SHIFT;
          bit_cnt_d  = '0;
          mism_cnt_d = '0;
          dec_gt_d   = 1'b0;
          dec_lt_d   = 1'b0;
          eq_d       = 1'b0;
          gt_d       = 1'b0;
          lt_d       = 1'b0;
        end
      end

      S_SHIFT: begin
        if (start) begin
          // Abort: restart the word, the bit presented this cycle is dropped.
          bit_cnt_d  = '0;
          mism_cnt_d = '0;
          dec_gt_d   = 1'b0;
          dec_lt_d   = 1'b0;
          eq_d       = 1'b0;
          gt_d       = 1'b0;
          lt_d       = 1'b0;
        end else if (in_valid) begin
          if (!bit_e && (mism_cnt_q < MAX_CNT)) begin
            mism_cnt_d = mism_cnt_q + ONE;
          end
`ifdef SERIAL_CMP_MSB_FIRST_EN
          // MSB first: the first difference is the most significant one.
          if (!bit_e && !dec_gt_q && !dec_lt_q) begin
            dec_gt_d = a;
            dec_lt_d = ~a;
          end
`else
          // LSB first: every later difference is more significant.
          if (!bit_e) begin
            dec_gt_d = a;
            dec_lt_d = ~a;
          end
`endif
          if (bit_cnt_q == LAST_IDX) begin
            bit_cnt_d = '0;
            state_d   = S_DONE;
            eq_d      = (mism_cnt_d == '0);
            gt_d      = dec_gt_d;
            lt_d      = dec_lt_d;
          end else begin
            bit_cnt_d = bit_cnt_q + ONE;
          end
        end
      end

      S_DONE: begin
        // start is ignored here; the strobe always completes.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and accumulator registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      mism_cnt_q <= '0;
      dec_gt_q   <= 1'b0;
      dec_lt_q   <= 1'b0;
      eq_q       <= 1'b0;
      gt_q       <= 1'b0;
      lt_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      mism_cnt_q <= mism_cnt_d;
      dec_gt_q   <= dec_gt_d;
      dec_lt_q   <= dec_lt_d;
      eq_q       <= eq_d;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
    end
  end

  // Handshake and status outputs decode the registered state only.
  assign in_ready  = (state_q == S_SHIFT);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign mism_cnt  = mism_cnt_q;

endmodule

// File: tb/tb_serial_word_cmp.sv
// Directed bench for serial_word_cmp at WIDTH=4. Bit order follows
// SERIAL_CMP_MSB_FIRST_EN so the same numeric words give the same verdict.
module tb_serial_word_cmp;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             res_valid;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CNT_W-1:0] mism_cnt;
  logic             busy;

  int errors = 0;
  int checks = 0;

  serial_word_cmp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .res_valid(res_valid),
    .eq       (eq),
    .gt       (gt),
    .lt       (lt),
    .mism_cnt (mism_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rv, input logic e_eq,
                          input logic e_gt, input logic e_lt, input logic [CNT_W-1:0] e_m);
    chk({tag, ".res_valid"}, {7'd0, res_valid}, {7'd0, e_rv});
    chk({tag, ".eq"}, {7'd0, eq}, {7'd0, e_eq});
    chk({tag, ".gt"}, {7'd0, gt}, {7'd0, e_gt});
    chk({tag, ".lt"}, {7'd0, lt}, {7'd0, e_lt});
    chk({tag, ".mism_cnt"}, 8'(mism_cnt), 8'(e_m));
  endtask

  function automatic int bit_idx(input int i);
`ifdef SERIAL_CMP_MSB_FIRST_EN
    return WIDTH - 1 - i;
`else
    return i;
`endif
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start.in_ready", {7'd0, in_ready}, 8'd1);
  endtask

  // Send a whole word from SHIFT; ends with the DUT in DONE.
  task automatic send_word(input string tag, input logic [3:0] av, input logic [3:0] bv,
                           input bit gaps, input logic e_eq, input logic e_gt,
                           input logic e_lt, input logic [CNT_W-1:0] e_m);
    bit early = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        a = 1'b1;
        b = 1'b0;
        tick();
        if (res_valid) early = 1'b1;
      end
      in_valid = 1'b1;
      a = av[bit_idx(i)];
      b = bv[bit_idx(i)];
      tick();
      if (i < WIDTH - 1 && res_valid) early = 1'b1;
    end
    in_valid = 1'b0;
    chk({tag, ".early_res_valid"}, {7'd0, early}, 8'd0);
    chk_outs(tag, 1'b1, e_eq, e_gt, e_lt, e_m);
    chk({tag, ".busy_done"}, {7'd0, busy}, 8'd1);
  endtask

  // Leave DONE; optionally hold start during DONE, which must be ignored.
  task automatic end_word(input string tag, input bit start_in_done);
    start = start_in_done;
    tick();
    start = 1'b0;
    chk({tag, ".strobe_one_cycle"}, {7'd0, res_valid}, 8'd0);
    chk({tag, ".idle_in_ready"}, {7'd0, in_ready}, 8'd0);
    chk({tag, ".idle_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("reset.in_ready", {7'd0, in_ready}, 8'd0);
    chk("reset.busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    tick();

    // 1: A=1010 B=0110 continuous -> gt, 2 mismatches
    do_start();
    send_word("s1", 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
    end_word("s1", 1'b0);
    chk_outs("s1.hold", 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);

    // 2: A=B=0101 -> eq; start in DONE ignored; then back-to-back lt word
    do_start();
    send_word("s2a", 4'b0101, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    end_word("s2a", 1'b1);
    do_start();
    send_word("s2b", 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    end_word("s2b", 1'b0);

    // 3: scenario 1 vectors with alternate idle cycles
    do_start();
    send_word("s3", 4'b1010, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
    end_word("s3", 1'b0);

    // 4: abort after 2 mismatching bits; bit presented with start dropped
    do_start();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = 1'b1; b = 1'b0;
      tick();
    end
    chk("s4.mid_mism", 8'(mism_cnt), 8'd2);
    start = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("s4.abort_mism", 8'(mism_cnt), 8'd0);
    chk("s4.abort_in_ready", {7'd0, in_ready}, 8'd1);
    send_word("s4", 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    end_word("s4", 1'b0);

    // 5: asynchronous reset after 3 accepted bits
    do_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 1'b1; b = 1'b0;
      tick();
    end
    chk("s5.mid_mism", 8'(mism_cnt), 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("s5.async", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("s5.async_in_ready", {7'd0, in_ready}, 8'd0);
    chk("s5.async_busy", {7'd0, busy}, 8'd0);
    tick();
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (res_valid || in_ready) seen = 1'b1;
      end
      chk("s5.no_result_without_start", {7'd0, seen}, 8'd0);
    end
    in_valid = 1'b0;
    do_start();
    send_word("s5", 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
    end_word("s5", 1'b0);

    // 6: all-different word saturates count at WIDTH; greater via top bit
    do_start();
    send_word("s6", 4'b1010, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4);
    end_word("s6", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
